// File: rtl/wb_pkg.sv
// Shared constants for the write-back stage: result-select codes, load funct3 codes, default width.
package wb_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [1:0] RES_ALU  = 2'd0;
    localparam logic [1:0] RES_LOAD = 2'd1;
    localparam logic [1:0] RES_PC4  = 2'd2;
    localparam logic [1:0] RES_IMM  = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner: picks byte/half/word from the raw memory word and sign/zero extends it.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // offset bit 0 is ignored for halves; misaligned halves never reach this stage
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   data_o = word_i;
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_pipe.sv
// M->W pipeline register with result select and load extension; one cycle M->W, StallW holds, FlushW kills.
// Optional retired-instruction counter InstRetW is built when WB_INSTRET_EN is defined.
module wb_pipe
    import wb_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int NUM_SRC = 4,
    parameter int RA_W    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       StallW,
    input  logic                       FlushW,
    input  logic                       ValidM,
    input  logic                       RegWriteM,
    input  logic [RA_W-1:0]            RdM,
    input  logic [$clog2(NUM_SRC)-1:0] ResultSrcM,
    input  logic [2:0]                 Funct3M,
    input  logic [XLEN-1:0]            ALUResultM,
    input  logic [XLEN-1:0]            ReadDataM,
    input  logic [XLEN-1:0]            PCPlus4M,
    input  logic [XLEN-1:0]            ImmExtM,
    output logic [XLEN-1:0]            ResultW,
    output logic [RA_W-1:0]            RdW,
    output logic                       RegWriteW,
    output logic                       ValidW
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]                InstRetW
`endif
);

    localparam int SRC_W = $clog2(NUM_SRC);

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic [RA_W-1:0]  rd;
        logic [SRC_W-1:0] src;
        logic [2:0]       funct3;
        logic [XLEN-1:0]  alu;
        logic [XLEN-1:0]  rdata;
        logic [XLEN-1:0]  pc4;
        logic [XLEN-1:0]  imm;
    } wreg_t;

    wreg_t           w_q, w_d;
    logic [XLEN-1:0] load_val;

    // Flush wins over stall; a flushed slot is fully zeroed so every field reads 0.
    always_comb begin
        w_d = w_q;
        if (FlushW) begin
            w_d = '0;
        end else if (!StallW) begin
            w_d.valid    = ValidM;
            w_d.regwrite = RegWriteM & ValidM & (RdM != '0);
            w_d.rd       = RdM;
            w_d.src      = ResultSrcM;
            w_d.funct3   = Funct3M;
            w_d.alu      = ALUResultM;
            w_d.rdata    = ReadDataM;
            w_d.pc4      = PCPlus4M;
            w_d.imm      = ImmExtM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .word_i  (w_q.rdata),
        .offset_i(w_q.alu[1:0]),
        .funct3_i(w_q.funct3),
        .data_o  (load_val)
    );

    // Unimplemented selects return 0 rather than X.
    always_comb begin
        ResultW = '0;
        case (w_q.src)
            RES_ALU:  ResultW = w_q.alu;
            RES_LOAD: ResultW = load_val;
            RES_PC4:  ResultW = w_q.pc4;
            RES_IMM:  ResultW = (NUM_SRC > 3) ? w_q.imm : '0;
            default:  ResultW = '0;
        endcase
    end

    assign RdW       = w_q.rd;
    assign RegWriteW = w_q.regwrite;
    assign ValidW    = w_q.valid;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // Counts the instruction leaving W, so a flush of the incoming slot does not cancel it.
    always_comb begin
        instret_d = instret_q;
        if (w_q.valid && !StallW) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign InstRetW = instret_q;
`endif

endmodule

// File: tb/tb_wb_pipe.sv
// Bench for wb_pipe: two instances (NUM_SRC=4 and NUM_SRC=3) share stimulus; expectations queued at drive time.
module tb_wb_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallW, FlushW, ValidM, RegWriteM;
    logic [4:0]  RdM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM;
    logic [31:0] ResultW4, ResultW3;
    logic [4:0]  RdW4, RdW3;
    logic        RegWriteW4, RegWriteW3, ValidW4, ValidW3;
`ifdef WB_INSTRET_EN
    logic [63:0] InstRetW4, InstRetW3;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] res4;
        logic [31:0] res3;
        logic [4:0]  rd;
        logic        rw;
        logic        vld;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    wb_pipe #(.XLEN(32), .NUM_SRC(4), .RA_W(5)) dut4 (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
        .ResultW(ResultW4), .RdW(RdW4), .RegWriteW(RegWriteW4), .ValidW(ValidW4)
`ifdef WB_INSTRET_EN
        , .InstRetW(InstRetW4)
`endif
    );

    wb_pipe #(.XLEN(32), .NUM_SRC(3), .RA_W(5)) dut3 (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
        .ResultW(ResultW3), .RdW(RdW3), .RegWriteW(RegWriteW3), .ValidW(ValidW3)
`ifdef WB_INSTRET_EN
        , .InstRetW(InstRetW3)
`endif
    );

    function automatic logic [31:0] model_res(input logic [1:0] src, input logic [2:0] f3,
                                              input logic [31:0] alu, input logic [31:0] rdat,
                                              input logic [31:0] pc4, input logic [31:0] imm,
                                              input int nsrc);
        logic [31:0] b, h, ld;
        b = (rdat >> (8 * alu[1:0])) & 32'h0000_00FF;
        h = (rdat >> (alu[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (f3)
            3'd0:    ld = b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd1:    ld = h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    ld = b;
            3'd5:    ld = h;
            default: ld = rdat;
        endcase
        case (src)
            2'd0:    return alu;
            2'd1:    return ld;
            2'd2:    return pc4;
            default: return (nsrc >= 4) ? imm : 32'd0;
        endcase
    endfunction

    // Drives one M-stage instruction at the falling edge and queues what W must show after the next edge.
    task automatic issue(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [31:0] exp4, input logic [31:0] exp3);
        exp_t e;
        @(negedge clk);
        ValidM = v; RegWriteM = rw; RdM = rd; ResultSrcM = src; Funct3M = f3;
        ALUResultM = alu; ReadDataM = rdat; PCPlus4M = pc4; ImmExtM = imm;
        e.res4 = exp4; e.res3 = exp3; e.rd = rd; e.rw = rw & v & (rd != 5'd0); e.vld = v;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        StallW = 0; FlushW = 0; ValidM = 1; RegWriteM = 1; RdM = 5'd9; ResultSrcM = 2'd2;
        Funct3M = 3'd0; ALUResultM = 32'h55; ReadDataM = 32'h66; PCPlus4M = 32'h77; ImmExtM = 32'h88;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (ValidW4 !== 1'b0) $display("FAIL reset_valid got=%b want=0", ValidW4); else pass_cnt++;
        total_cnt++; if (RegWriteW4 !== 1'b0) $display("FAIL reset_regwrite got=%b want=0", RegWriteW4); else pass_cnt++;
        total_cnt++; if (RdW4 !== 5'd0) $display("FAIL reset_rd got=%0d want=0", RdW4); else pass_cnt++;
        total_cnt++; if (ResultW4 !== 32'd0) $display("FAIL reset_result got=%h want=0", ResultW4); else pass_cnt++;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3s [9]  = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd5, 3'd2, 3'd1, 3'd1, 3'd7};
        logic [31:0] alus[9]  = '{32'h1001, 32'h1002, 32'h1003, 32'h1002, 32'h1002, 32'h1003,
                                  32'h1000, 32'h1001, 32'h1000};
        logic [31:0] exps[9]  = '{32'h0000_007F, 32'h0000_00FF, 32'hFFFF_FF80, 32'hFFFF_80FF,
                                  32'h0000_80FF, 32'h80FF_7F01, 32'h0000_7F01, 32'h0000_7F01,
                                  32'h80FF_7F01};
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            issue(1'b1, 1'b1, 5'd3, 2'd1, f3s[i], alus[i], 32'h80FF_7F01, 32'h4, 32'h0, exps[i], exps[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            total_cnt++;
            if (ResultW4 !== e.res4) $display("FAIL load_ext[%0d] got=%h want=%h", i, ResultW4, e.res4);
            else pass_cnt++;
        end
    endtask

    task automatic test_regwrite;
        logic       vs [3] = '{1'b1, 1'b1, 1'b0};
        logic [4:0] rds[3] = '{5'd0, 5'd5, 5'd6};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(vs[i], 1'b1, rds[i], 2'd0, 3'd2, 32'hA0 + i, 32'h0, 32'h0, 32'h0, 32'hA0 + i, 32'hA0 + i);
            @(posedge clk); #1;
            e = sb.pop_front();
            total_cnt++;
            if (RegWriteW4 !== e.rw) $display("FAIL regwrite[%0d] got=%b want=%b", i, RegWriteW4, e.rw);
            else pass_cnt++;
            total_cnt++;
            if (RdW4 !== e.rd || ValidW4 !== e.vld)
                $display("FAIL rd_valid[%0d] got=%0d/%b want=%0d/%b", i, RdW4, ValidW4, e.rd, e.vld);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall_flush;
        exp_t e;
        issue(1'b1, 1'b1, 5'd12, 2'd2, 3'd0, 32'h11, 32'h22, 32'h0000_0334, 32'h44, 32'h334, 32'h334);
        @(posedge clk); #1;
        e = sb.pop_front();
        total_cnt++;
        if (ResultW4 !== e.res4) $display("FAIL stall_capture got=%h want=%h", ResultW4, e.res4); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            StallW = 1; ValidM = i[0]; RegWriteM = 0; RdM = 5'(20 + i); ResultSrcM = 2'(i);
            ALUResultM = $urandom; PCPlus4M = $urandom; ReadDataM = $urandom;
            @(posedge clk); #1;
            total_cnt++;
            if (ResultW4 !== e.res4 || RdW4 !== e.rd || RegWriteW4 !== e.rw || ValidW4 !== e.vld)
                $display("FAIL stall_hold[%0d] got=%h/%0d/%b/%b want=%h/%0d/%b/%b", i,
                         ResultW4, RdW4, RegWriteW4, ValidW4, e.res4, e.rd, e.rw, e.vld);
            else pass_cnt++;
        end
        @(negedge clk);
        FlushW = 1; ValidM = 1; RegWriteM = 1; RdM = 5'd9;
        @(posedge clk); #1;
        total_cnt++;
        if (ValidW4 !== 1'b0 || RegWriteW4 !== 1'b0)
            $display("FAIL stall_flush got=%b/%b want=0/0", ValidW4, RegWriteW4);
        else pass_cnt++;
        total_cnt++;
        if (RdW4 !== 5'd0 || ResultW4 !== 32'd0)
            $display("FAIL flush_zero got=%0d/%h want=0/0", RdW4, ResultW4);
        else pass_cnt++;
        @(negedge clk);
        StallW = 0; FlushW = 0;
    endtask

    task automatic test_src_sel;
        logic [1:0]  srcs[3] = '{2'd3, 2'd0, 2'd2};
        logic [31:0] e4s [3] = '{32'h1234, 32'hBEEF, 32'h100};
        logic [31:0] e3s [3] = '{32'h0, 32'hBEEF, 32'h100};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 1'b1, 5'd1, srcs[i], 3'd2, 32'hBEEF, 32'hDEAD, 32'h100, 32'h1234, e4s[i], e3s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            total_cnt++;
            if (ResultW4 !== e.res4) $display("FAIL src4[%0d] got=%h want=%h", i, ResultW4, e.res4); else pass_cnt++;
            total_cnt++;
            if (ResultW3 !== e.res3) $display("FAIL src3[%0d] got=%h want=%h", i, ResultW3, e.res3); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic        v, rw;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [31:0] alu, rdat, pc4, imm;
        for (int i = 0; i < 24; i++) begin
            v = 1'($urandom_range(0, 3) != 0); rw = 1'($urandom); rd = 5'($urandom_range(0, 31));
            src = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7));
            alu = $urandom; rdat = $urandom; pc4 = $urandom; imm = $urandom;
            issue(v, rw, rd, src, f3, alu, rdat, pc4, imm,
                  model_res(src, f3, alu, rdat, pc4, imm, 4), model_res(src, f3, alu, rdat, pc4, imm, 3));
            @(posedge clk); #1;
            e = sb.pop_front();
            total_cnt++;
            if (ResultW4 !== e.res4 || RdW4 !== e.rd || RegWriteW4 !== e.rw || ValidW4 !== e.vld)
                $display("FAIL b2b4[%0d] got=%h/%0d/%b/%b want=%h/%0d/%b/%b", i,
                         ResultW4, RdW4, RegWriteW4, ValidW4, e.res4, e.rd, e.rw, e.vld);
            else pass_cnt++;
            total_cnt++;
            if (ResultW3 !== e.res3 || RdW3 !== e.rd || RegWriteW3 !== e.rw || ValidW3 !== e.vld)
                $display("FAIL b2b3[%0d] got=%h/%0d/%b/%b want=%h/%0d/%b/%b", i,
                         ResultW3, RdW3, RegWriteW3, ValidW3, e.res3, e.rd, e.rw, e.vld);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_override;
        exp_t e;
        @(negedge clk);
        StallW = 1; FlushW = 1; ValidM = 1;
        #2 reset = 1;
        #1;
        total_cnt++;
        if (ValidW4 !== 1'b0 || RegWriteW4 !== 1'b0 || RdW4 !== 5'd0 || ResultW4 !== 32'd0)
            $display("FAIL async_reset got=%b/%b/%0d/%h want=0/0/0/0", ValidW4, RegWriteW4, RdW4, ResultW4);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        reset = 0; StallW = 0; FlushW = 0;
        issue(1'b1, 1'b1, 5'd7, 2'd0, 3'd2, 32'h0000_CAFE, 32'h0, 32'h0, 32'h0, 32'hCAFE, 32'hCAFE);
        @(posedge clk); #1;
        e = sb.pop_front();
        total_cnt++;
        if (ResultW4 !== e.res4 || RdW4 !== e.rd || RegWriteW4 !== e.rw || ValidW4 !== e.vld)
            $display("FAIL post_reset got=%h/%0d/%b/%b want=%h/%0d/%b/%b",
                     ResultW4, RdW4, RegWriteW4, ValidW4, e.res4, e.rd, e.rw, e.vld);
        else pass_cnt++;
    endtask

`ifdef WB_INSTRET_EN
    task automatic test_instret;
        @(negedge clk);
        StallW = 0; FlushW = 0; ValidM = 0;
        #2 reset = 1;
        #1;
        total_cnt++;
        if (InstRetW4 !== 64'd0) $display("FAIL instret_reset got=%0d want=0", InstRetW4); else pass_cnt++;
        @(negedge clk);
        reset = 0; ValidM = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        ValidM = 0;
        @(posedge clk); #1;
        total_cnt++;
        if (InstRetW4 !== 64'd10 || InstRetW3 !== 64'd10)
            $display("FAIL instret_10 got=%0d/%0d want=10", InstRetW4, InstRetW3);
        else pass_cnt++;
        @(negedge clk);
        ValidM = 1;
        @(posedge clk);
        @(negedge clk);
        StallW = 1;
        @(posedge clk); #1;
        total_cnt++;
        if (InstRetW4 !== 64'd10) $display("FAIL instret_stall got=%0d want=10", InstRetW4); else pass_cnt++;
        @(negedge clk);
        StallW = 0; FlushW = 1;
        @(posedge clk); #1;
        total_cnt++;
        if (InstRetW4 !== 64'd11) $display("FAIL instret_flush got=%0d want=11", InstRetW4); else pass_cnt++;
        @(negedge clk);
        FlushW = 0; ValidM = 1;
        @(posedge clk);
        @(negedge clk);
        force dut4.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut4.instret_q;
        @(posedge clk); #1;
        total_cnt++;
        if (InstRetW4 !== 64'd0) $display("FAIL instret_wrap got=%h want=0", InstRetW4); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (InstRetW4 !== 64'd1) $display("FAIL instret_after_wrap got=%0d want=1", InstRetW4); else pass_cnt++;
        #2 reset = 1;
        #1;
        total_cnt++;
        if (InstRetW4 !== 64'd0) $display("FAIL instret_async_reset got=%0d want=0", InstRetW4); else pass_cnt++;
        @(negedge clk);
        reset = 0; ValidM = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_ext();
        test_regwrite();
        test_stall_flush();
        test_src_sel();
        test_back_to_back();
        test_reset_override();
`ifdef WB_INSTRET_EN
        test_instret();
`endif
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d want=0", sb.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_pipe.md
WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_SRC, default 4, number of result sources (range 3..4).
REQ-003 SHALL have parameter RA_W, default 5, register-address width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high (ports clk, reset).
REQ-005 SHALL have ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- StallW  in  1  hold W register
- FlushW  in  1  kill instruction entering W
- ValidM  in  1  M-stage instruction valid
- RegWriteM  in  1  register write request
- RdM  in  RA_W  destination register
- ResultSrcM  in  $clog2(NUM_SRC)  result select
- Funct3M  in  3  load size/sign
- ALUResultM  in  XLEN  ALU result / load address
- ReadDataM  in  XLEN  raw memory word
- PCPlus4M  in  XLEN  PC+4
- ImmExtM  in  XLEN  immediate (source 3, used when NUM_SRC=4)
- ResultW  out  XLEN  write-back value
- RdW  out  RA_W  destination register
- RegWriteW  out  1  register-file write enable
- ValidW  out  1  W-stage instruction valid
- InstRetW  out  64  retired-instruction count (only with WB_INSTRET_EN)

Function
REQ-006 SHALL register all M inputs into a W register on rising clk; latency exactly one cycle M->W.
REQ-007 ResultW SHALL be combinational from W-register contents only.
REQ-008 Priority per edge: reset > FlushW > StallW > capture.
REQ-009 FlushW SHALL clear ValidW and RegWriteW at next edge; other W fields don't-care but SHALL read as 0.
REQ-010 StallW (no flush) SHALL hold every W field unchanged.
REQ-011 RegWriteW SHALL equal registered (RegWriteM & ValidM & RdM!=0).
REQ-012 Select 0 -> ALU result; 1 -> extended load data; 2 -> PC+4; 3 -> immediate.
REQ-013 Select >= NUM_SRC SHALL give ResultW = 0 (no X).
REQ-014 Load extension uses registered ALUResult[1:0] as byte offset:
- 000 LB: byte[offset], sign-extend
- 001 LH: half[ALUResult[1]], sign-extend
- 010 LW: full word
- 100 LBU / 101 LHU: as LB/LH, zero-extend
- any other funct3: full word
REQ-015 Halfword load ignores ALUResult[0] (misalignment trapped upstream).

Reset
REQ-016 Reset SHALL asynchronously force ValidW=0, RegWriteW=0, RdW=0, ResultW=0, all W fields 0, InstRetW=0.
REQ-017 Reset asserted mid-stall or mid-flush SHALL override both; first post-reset edge captures normally.

Configuration
REQ-018 With macro WB_INSTRET_EN defined, SHALL include 64-bit InstRetW counter, +1 at each edge where ValidW=1 and StallW=0, regardless of FlushW; wraps 2^64-1 -> 0.
REQ-019 Without WB_INSTRET_EN, port InstRetW and counter SHALL be absent; all other behaviour identical.

Structure
REQ-020 Package wb_pkg SHALL hold result-select constants (RES_ALU=0, RES_LOAD=1, RES_PC4=2, RES_IMM=3), load funct3 constants, default XLEN.
REQ-021 Sub-module load_extend SHALL be combinational (word, offset, funct3 -> XLEN value); instantiated once.

Verification
REQ-022 Bench SHALL cover:
- ReadDataM=0x80FF_7F01, ALUResultM=0x1001, Funct3M=000, ResultSrcM=1 -> next cycle ResultW=0x0000_007F; Funct3M=100, offset 2 -> 0x0000_00FF; offset 3 -> 0xFFFF_FF80.
- Same word, Funct3M=001, offset 2 -> 0xFFFF_80FF; Funct3M=101 -> 0x0000_80FF.
- RegWriteM=1, RdM=0, ValidM=1 -> RegWriteW=0; RdM=5 -> RegWriteW=1, RdW=5.
- StallW=1 for 3 cycles with changing M inputs -> W outputs constant; StallW=1 and FlushW=1 together -> ValidW=0, RegWriteW=0.
- ResultSrcM=3, NUM_SRC=3 -> ResultW=0; NUM_SRC=4, ImmExtM=0x1234 -> 0x1234.
- WB_INSTRET_EN: 10 valid unstalled instructions -> InstRetW=10; counter preset near 2^64-1 wraps to 0; reset asserted between edges -> InstRetW=0 immediately.
